// File: rtl/f_function.sv
//------------------------------------------------------------------------------
// Module   : f_function
// Purpose  : Two-input Boolean function generator (4:1 mux over a loadable
//            truth table), with a registered copy of the result.
// Options  : F_FUNCTION_TOGGLE_CNT_EN enables the f_q rising-edge counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module f_function #(
    parameter logic [3:0] TRUTH_TABLE = 4'b0110,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_tt,
    output logic [3:0]       tt,
    output logic             f,
    output logic             f_q,
    output logic [CNT_W-1:0] tog_cnt
);

    logic [3:0] tt_q;
    logic [3:0] tt_d;

    always_comb begin
        tt_d = tt_q;
        if (cfg_we) begin
            tt_d = cfg_tt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt_q <= TRUTH_TABLE;
            f_q  <= 1'b0;
        end else begin
            tt_q <= tt_d;
            f_q  <= f;
        end
    end

    // Select with {A,B}; an unknown select deliberately propagates as X.
    assign f  = tt_q[{A, B}];
    assign tt = tt_q;

`ifdef F_FUNCTION_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A 0->1 transition of f_q is predicted from the pre-edge f_q and f.
    always_comb begin
        cnt_d = cnt_q;
        if (!f_q && f) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tog_cnt = cnt_q;
`else
    assign tog_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_f_function.sv
//------------------------------------------------------------------------------
// Module   : tb_f_function
// Purpose  : Directed, table-driven self-checking bench for f_function.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_f_function;

    localparam int CNT_W = 2;
`ifdef F_FUNCTION_TOGGLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             A;
    logic             B;
    logic             cfg_we;
    logic [3:0]       cfg_tt;
    logic [3:0]       tt;
    logic             f;
    logic             f_q;
    logic [CNT_W-1:0] tog_cnt;

    int n_total;
    int n_pass;

    f_function #(
        .TRUTH_TABLE (4'b0110),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .cfg_we  (cfg_we),
        .cfg_tt  (cfg_tt),
        .tt      (tt),
        .f       (f),
        .f_q     (f_q),
        .tog_cnt (tog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       we;
        logic [3:0] cfg;
        logic       a;
        logic       b;
        logic       exp_f;   // f before the edge
        logic [3:0] exp_tt;  // tt after the edge
        logic       exp_fq;  // f_q after the edge
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst_n  = v.rst_n;
        cfg_we = v.we;
        cfg_tt = v.cfg;
        A      = v.a;
        B      = v.b;
        #1;
        check($sformatf("vec%0d_f", idx), {31'd0, f}, {31'd0, v.exp_f});
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_tt", idx), {28'd0, tt}, {28'd0, v.exp_tt});
        check($sformatf("vec%0d_fq", idx), {31'd0, f_q}, {31'd0, v.exp_fq});
    endtask

    task automatic drive_ab(input logic a, input logic b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        //            rst  we  cfg      a  b  f   tt       fq
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b1};
        // XNOR written while {A,B}=01: f_q keeps the old-table value one edge.
        vecs[10] = '{1'b1, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 4'b1110, 1'b1};
        // Reset wins over a simultaneous config write.
        vecs[13] = '{1'b0, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0};

        rst_n  = 1'b0;
        cfg_we = 1'b0;
        cfg_tt = 4'b0000;
        A      = 1'b0;
        B      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tt", {28'd0, tt}, 32'h6);
        check("reset_fq", {31'd0, f_q}, 32'h0);
        check("reset_cnt", {30'd0, tog_cnt}, 32'h0);
        check("reset_f00", {31'd0, f}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], i);
        end

        // Input changes between edges: f follows immediately, f_q waits for clk.
        @(negedge clk);
        A = 1'b0;
        B = 1'b1;
        #1;
        check("async_f_01", {31'd0, f}, 32'h1);
        check("async_fq_hold0", {31'd0, f_q}, 32'h0);
        #1;
        B = 1'b0;
        #1;
        check("async_f_00", {31'd0, f}, 32'h0);
        B = 1'b1;
        #1;
        check("async_fq_still0", {31'd0, f_q}, 32'h0);
        @(posedge clk);
        #1;
        check("async_fq_edge", {31'd0, f_q}, 32'h1);
        A = 1'b1;
        #1;
        check("async_f_11", {31'd0, f}, 32'h0);
        check("async_fq_hold1", {31'd0, f_q}, 32'h1);

        // Toggle counter: fresh reset, then 00<->01 for five f_q rises.
        @(negedge clk);
        rst_n = 1'b0;
        A     = 1'b0;
        B     = 1'b0;
        @(posedge clk);
        #1;
        check("cnt_clear", {30'd0, tog_cnt}, 32'h0);
        rst_n = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            drive_ab(1'b0, 1'b1);
            check($sformatf("cnt_rise%0d", r), {30'd0, tog_cnt},
                  CNT_EN ? (32'(r) % 32'd4) : 32'h0);
            drive_ab(1'b0, 1'b0);
        end
        check("cnt_final", {30'd0, tog_cnt}, CNT_EN ? 32'h1 : 32'h0);
        // Holding f high must not count again.
        drive_ab(1'b0, 1'b1);
        drive_ab(1'b0, 1'b1);
        check("cnt_hold_high", {30'd0, tog_cnt}, CNT_EN ? 32'h2 : 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
